// File: rtl/x2050roar.sv
// x2050roar: ROS address register (ROAR) sequencer with a registered microword
// stage and a valid/ready handshake toward the microword consumer.
module x2050roar #(
  parameter logic [11:0] RESET_ADDR = 12'h000,
  parameter bit          AUTOSTART  = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [11:0] o_ros_addr,
  input  logic [89:0] i_ros_data,
  input  logic        i_start,
  input  logic [11:0] i_start_addr,
  input  logic [1:0]  i_cond,
  input  logic        i_stop,
  output logic [89:0] o_rosdr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_halted,
  output logic [15:0] o_count
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HALT} state_t;
  localparam state_t RESET_STATE = AUTOSTART ? FETCH : IDLE;

  state_t      r_state, w_next;
  logic [11:0] r_roar;
  logic [89:0] r_rosdr;
  logic        r_valid, r_halted;
  logic [15:0] r_count;
  logic        w_hs, w_start, w_hold;
  logic [1:0]  w_mode;
  logic [11:0] w_base, w_next_addr;

  assign w_hs    = (r_state == PRESENT) & i_ready;
  assign w_start = ((r_state == IDLE) | (r_state == HALT)) & i_start;
  assign w_base  = r_rosdr[11:0];
  assign w_mode  = r_rosdr[13:12];
  assign w_hold  = w_mode == 2'b11;
  // Next address is purely bitwise: no sequential increment exists.
  assign w_next_addr = w_mode == 2'b00 ? w_base :
                       w_mode == 2'b01 ? {w_base[11:1], w_base[0] | i_cond[0]} :
                                         {w_base[11:2], i_cond};

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= RESET_STATE;
    else         r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? FETCH : IDLE;
      FETCH:   w_next = PRESENT;
      PRESENT: w_next = !i_ready ? PRESENT : i_stop ? IDLE : w_hold ? HALT : FETCH;
      HALT:    w_next = i_start ? FETCH : i_stop ? IDLE : HALT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_roar   <= RESET_ADDR;
      r_rosdr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_start) r_roar <= i_start_addr;
      else if (w_hs && !i_stop && !w_hold) r_roar <= w_next_addr;
      if (r_state == FETCH) begin
        r_rosdr <= i_ros_data;
        r_valid <= 1'b1;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        r_count <= r_count + 16'd1;
      end
      // Start beats stop when both arrive in HALT; either one clears the flag.
      if (w_hs && !i_stop && w_hold) r_halted <= 1'b1;
      else if (r_state == HALT && (i_start || i_stop)) r_halted <= 1'b0;
    end

  always_comb begin
    o_ros_addr = r_roar;
    o_rosdr    = r_rosdr;
    o_valid    = r_valid;
    o_halted   = r_halted;
    o_count    = r_count;
  end
endmodule
